// File: rtl/dispatch_reconfig_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_reconfig_ctrl_pkg
// Shared types for the dispatch/back-end reconfiguration controller.
//   - rcState_t : sequencing FSM states (IDLE, DRAIN, FLUSH, SETTLE)
//   - rcMask_t  : bundle of the four resource masks (lanes, IQ, AL, LSQ)
//   - maskLegal : a request is legal only if lane 0 / partition 0 of every
//                 structure stays enabled, so the core always keeps a
//                 minimum working configuration.
//   - cntWidth  : counter width able to hold 0..n-1 (never narrower than 1).
// The mask widths below set the resource configuration of the build; the
// controller's width parameters default to these values.
// -----------------------------------------------------------------------------
package dispatch_reconfig_ctrl_pkg;

  localparam int LANE_W = 4;
  localparam int IQ_W   = 4;
  localparam int AL_W   = 4;
  localparam int LSQ_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FLUSH  = 2'd2,
    SETTLE = 2'd3
  } rcState_t;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [IQ_W-1:0]   iq;
    logic [AL_W-1:0]   al;
    logic [LSQ_W-1:0]  lsq;
  } rcMask_t;

  // Out of reset every lane and partition is enabled.
  localparam rcMask_t MASK_RESET = '1;

  function automatic logic maskLegal(input rcMask_t m);
    return m.lane[0] & m.iq[0] & m.al[0] & m.lsq[0];
  endfunction

  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dispatch_reconfig_ctrl_mask_reg.sv
// -----------------------------------------------------------------------------
// reconfig_mask_reg
// Legality check plus two-stage storage of the resource masks.
//   clk, reset  : clock, synchronous active-high reset
//   reqMask     : requested masks straight from the request inputs
//   latchEn     : capture reqMask into the pending register (request accepted)
//   commitEn    : copy pending into the active register (end of FLUSH)
//   reqLegal    : combinational legality of reqMask
//   activeMask  : committed masks driving the dispatch/back-end enables
// The pending copy decouples the accepted request from whatever the request
// inputs do while the back end drains.
// -----------------------------------------------------------------------------
module reconfig_mask_reg
  import dispatch_reconfig_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  rcMask_t reqMask,
  input  logic    latchEn,
  input  logic    commitEn,
  output logic    reqLegal,
  output rcMask_t activeMask
);

  rcMask_t pendingQ;
  rcMask_t activeQ;

  assign reqLegal   = maskLegal(reqMask);
  assign activeMask = activeQ;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingQ <= '0;
      activeQ  <= MASK_RESET;
    end else begin
      if (latchEn)  pendingQ <= reqMask;
      if (commitEn) activeQ  <= pendingQ;
    end
  end

endmodule

// File: rtl/dispatch_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_reconfig_ctrl
// Sequences a dynamic reconfiguration of dispatch lanes and AL/IQ/LSQ
// partitions: stall dispatch, wait for the back end to drain, pulse
// reconfigureCore (flushes rename-dispatch, resets pre-steering), commit the
// new masks, then hold the stall for a settle window.
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   reconfigReq_i            : request, only looked at in IDLE
//   new*_i                   : requested lane / partition masks
//   *Cnt_i, renameReady_i    : back-end occupancy and rename valid (drain test)
//   stallDispatch_o, busy_o  : high while DRAIN, FLUSH or SETTLE
//   reconfigureCore_o        : one-cycle pulse during FLUSH
//   *Active_o                : committed masks (all-ones out of reset)
//   done_o/reject_o/abort_o  : one-cycle completion / illegal / timeout pulses
// Every output comes from a flop: state-derived outputs are registered from
// the next-state value so they line up with the state they describe.
// -----------------------------------------------------------------------------
module dispatch_reconfig_ctrl
  import dispatch_reconfig_ctrl_pkg::*;
#(
  parameter int DISPATCH_WIDTH   = LANE_W,
  parameter int NUM_PARTS_IQ     = IQ_W,
  parameter int NUM_PARTS_AL     = AL_W,
  parameter int STRUCT_PARTS_LSQ = LSQ_W,
  parameter int CNT_W            = 8,
  parameter int SETTLE_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reconfigReq_i,
  input  logic [DISPATCH_WIDTH-1:0]   newDispatchLane_i,
  input  logic [NUM_PARTS_IQ-1:0]     newIqPart_i,
  input  logic [NUM_PARTS_AL-1:0]     newAlPart_i,
  input  logic [STRUCT_PARTS_LSQ-1:0] newLsqPart_i,
  input  logic [CNT_W-1:0]            activeListCnt_i,
  input  logic [CNT_W-1:0]            issueQueueCnt_i,
  input  logic [CNT_W-1:0]            loadQueueCnt_i,
  input  logic [CNT_W-1:0]            storeQueueCnt_i,
  input  logic                        renameReady_i,
  output logic                        stallDispatch_o,
  output logic                        reconfigureCore_o,
  output logic [DISPATCH_WIDTH-1:0]   dispatchLaneActive_o,
  output logic [NUM_PARTS_IQ-1:0]     iqPartitionActive_o,
  output logic [NUM_PARTS_AL-1:0]     alPartitionActive_o,
  output logic [STRUCT_PARTS_LSQ-1:0] lsqPartitionActive_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        reject_o,
  output logic                        abort_o
);

  localparam int DRAIN_W   = cntWidth(DRAIN_TIMEOUT);
  localparam int SETTLE_W  = cntWidth(SETTLE_CYCLES);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  rcState_t            stateQ,      stateNext;
  logic [DRAIN_W-1:0]  drainCntQ,   drainCntNext;
  logic [SETTLE_W-1:0] settleCntQ,  settleCntNext;

  logic busyQ, coreQ, doneQ, rejectQ, abortQ;
  logic doneNext, rejectNext, abortNext;
  logic acceptReq, commitMask, reqLegal, backEndEmpty;

  rcMask_t reqMask, activeMask;

  assign reqMask = '{lane: newDispatchLane_i, iq: newIqPart_i,
                     al: newAlPart_i, lsq: newLsqPart_i};

  // Any set bit in any occupancy count, or a valid bundle waiting in rename,
  // means instructions are still in flight.
  assign backEndEmpty = ~|{activeListCnt_i, issueQueueCnt_i,
                           loadQueueCnt_i, storeQueueCnt_i} & ~renameReady_i;

  reconfig_mask_reg uMaskReg (
    .clk        (clk),
    .reset      (reset),
    .reqMask    (reqMask),
    .latchEn    (acceptReq),
    .commitEn   (commitMask),
    .reqLegal   (reqLegal),
    .activeMask (activeMask)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    stateNext     = stateQ;
    drainCntNext  = drainCntQ;
    settleCntNext = settleCntQ;
    acceptReq     = 1'b0;
    commitMask    = 1'b0;
    doneNext      = 1'b0;
    rejectNext    = 1'b0;
    abortNext     = 1'b0;

    case (stateQ)
      IDLE: begin
        drainCntNext  = '0;
        settleCntNext = '0;
        if (reconfigReq_i) begin
          if (reqLegal) begin
            acceptReq = 1'b1;
            stateNext = DRAIN;
          end else begin
            rejectNext = 1'b1;
          end
        end
      end

      DRAIN: begin
        // Empty is tested before the timeout so a drain that completes on
        // the last allowed cycle still reconfigures.
        if (backEndEmpty) begin
          drainCntNext = '0;
          stateNext    = FLUSH;
        end else if (drainCntQ == DRAIN_LAST) begin
          drainCntNext = '0;
          abortNext    = 1'b1;
          stateNext    = IDLE;
        end else begin
          drainCntNext = drainCntQ + 1'b1;
        end
      end

      FLUSH: begin
        commitMask    = 1'b1;
        settleCntNext = '0;
        stateNext     = SETTLE;
      end

      SETTLE: begin
        if (settleCntQ == SETTLE_LAST) begin
          settleCntNext = '0;
          doneNext      = 1'b1;
          stateNext     = IDLE;
        end else begin
          settleCntNext = settleCntQ + 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= IDLE;
      drainCntQ  <= '0;
      settleCntQ <= '0;
      busyQ      <= 1'b0;
      coreQ      <= 1'b0;
      doneQ      <= 1'b0;
      rejectQ    <= 1'b0;
      abortQ     <= 1'b0;
    end else begin
      stateQ     <= stateNext;
      drainCntQ  <= drainCntNext;
      settleCntQ <= settleCntNext;
      busyQ      <= (stateNext != IDLE);
      coreQ      <= (stateNext == FLUSH);
      doneQ      <= doneNext;
      rejectQ    <= rejectNext;
      abortQ     <= abortNext;
    end
  end

  assign stallDispatch_o      = busyQ;
  assign busy_o               = busyQ;
  assign reconfigureCore_o    = coreQ;
  assign done_o               = doneQ;
  assign reject_o             = rejectQ;
  assign abort_o              = abortQ;
  assign dispatchLaneActive_o = activeMask.lane;
  assign iqPartitionActive_o  = activeMask.iq;
  assign alPartitionActive_o  = activeMask.al;
  assign lsqPartitionActive_o = activeMask.lsq;

endmodule

// File: tb/tb_dispatch_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dispatch_reconfig_ctrl
// Scoreboarded bench. The stimulus side predicts, from the request masks and
// the number of cycles it keeps the back end occupied, which pulse events the
// controller must produce (cycle and mask state) and which cycles it must be
// busy. A negedge monitor compares busy/stall every cycle and pops one
// expected event for every pulse the controller presents.
// Masks are handled packed as {lane[3:0], iq[3:0], al[3:0], lsq[1:0]}.
// -----------------------------------------------------------------------------
module tb_dispatch_reconfig_ctrl;

  localparam int SETTLE = 4;
  localparam int TO     = 1024;
  localparam int MAXC   = 20000;
  localparam logic [13:0] ALL_ONES = 14'h3FFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       reconfigReq_i;
  logic [3:0] newDispatchLane_i, newIqPart_i, newAlPart_i;
  logic [1:0] newLsqPart_i;
  logic [7:0] activeListCnt_i, issueQueueCnt_i, loadQueueCnt_i, storeQueueCnt_i;
  logic       renameReady_i;
  logic       stallDispatch_o, reconfigureCore_o, busy_o, done_o, reject_o, abort_o;
  logic [3:0] dispatchLaneActive_o, iqPartitionActive_o, alPartitionActive_o;
  logic [1:0] lsqPartitionActive_o;
  logic [13:0] dutMask;

  always #5 clk = ~clk;

  dispatch_reconfig_ctrl #(
    .DISPATCH_WIDTH(4), .NUM_PARTS_IQ(4), .NUM_PARTS_AL(4), .STRUCT_PARTS_LSQ(2),
    .CNT_W(8), .SETTLE_CYCLES(SETTLE), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .reconfigReq_i(reconfigReq_i),
    .newDispatchLane_i(newDispatchLane_i), .newIqPart_i(newIqPart_i),
    .newAlPart_i(newAlPart_i), .newLsqPart_i(newLsqPart_i),
    .activeListCnt_i(activeListCnt_i), .issueQueueCnt_i(issueQueueCnt_i),
    .loadQueueCnt_i(loadQueueCnt_i), .storeQueueCnt_i(storeQueueCnt_i),
    .renameReady_i(renameReady_i), .stallDispatch_o(stallDispatch_o),
    .reconfigureCore_o(reconfigureCore_o),
    .dispatchLaneActive_o(dispatchLaneActive_o), .iqPartitionActive_o(iqPartitionActive_o),
    .alPartitionActive_o(alPartitionActive_o), .lsqPartitionActive_o(lsqPartitionActive_o),
    .busy_o(busy_o), .done_o(done_o), .reject_o(reject_o), .abort_o(abort_o)
  );

  assign dutMask = {dispatchLaneActive_o, iqPartitionActive_o,
                    alPartitionActive_o, lsqPartitionActive_o};

  typedef enum int {EV_CORE = 1, EV_DONE = 2, EV_REJECT = 3, EV_ABORT = 4} evKind_t;
  typedef struct {
    evKind_t     kind;
    int          cycle;
    logic [13:0] masks;
  } ev_t;

  ev_t         expQ[$];
  bit          expBusy[MAXC];
  logic [13:0] modelMask;
  bit          monOn = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: busy/stall every cycle, one expected event per pulse.
  always @(negedge clk) begin
    evKind_t k;
    ev_t     e;
    if (monOn && cyc < MAXC) begin
      check("busy", {31'd0, busy_o}, {31'd0, expBusy[cyc]});
      check("stall", {31'd0, stallDispatch_o}, {31'd0, expBusy[cyc]});
      if (reconfigureCore_o | done_o | reject_o | abort_o) begin
        k = reconfigureCore_o ? EV_CORE : done_o ? EV_DONE : reject_o ? EV_REJECT : EV_ABORT;
        check("pulse_onehot", $countones({reconfigureCore_o, done_o, reject_o, abort_o}), 1);
        if (expQ.size() == 0) begin
          check("unexpected_event", k, 0);
        end else begin
          e = expQ.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.cycle);
          check("event_masks", {18'd0, dutMask}, {18'd0, e.masks});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveEmpty();
    activeListCnt_i = '0; issueQueueCnt_i = '0;
    loadQueueCnt_i  = '0; storeQueueCnt_i = '0;
    renameReady_i   = 1'b0;
  endtask

  // Back end not empty. mode 0: random mix with one guaranteed source,
  // mode 1: only rename holds a bundle, mode 2: only the SQ count MSB set.
  task automatic driveOccupied(input int mode);
    int src;
    driveEmpty();
    if (mode == 1) begin
      renameReady_i = 1'b1;
    end else if (mode == 2) begin
      storeQueueCnt_i = 8'h80;
    end else begin
      activeListCnt_i = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
      issueQueueCnt_i = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
      loadQueueCnt_i  = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
      storeQueueCnt_i = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
      renameReady_i   = 1'($urandom_range(0, 1));
      src = $urandom_range(0, 4);
      case (src)
        0: activeListCnt_i = 8'd1 << $urandom_range(0, 7);
        1: issueQueueCnt_i = 8'd1 << $urandom_range(0, 7);
        2: loadQueueCnt_i  = 8'd1 << $urandom_range(0, 7);
        3: storeQueueCnt_i = 8'd1 << $urandom_range(0, 7);
        default: renameReady_i = 1'b1;
      endcase
    end
  endtask

  task automatic setReq(input logic [13:0] m);
    {newDispatchLane_i, newIqPart_i, newAlPart_i, newLsqPart_i} = m;
  endtask

  // One request, issued in the current cycle t. The back end stays occupied
  // for 'hold' cycles after t, so the first empty DRAIN cycle is t+1+hold.
  task automatic doTxn(input logic [13:0] m, input int hold, input int mode, input bit inject);
    int t, idleAt;
    bit legal;
    t     = cyc;
    legal = m[10] & m[6] & m[2] & m[0];
    setReq(m);
    reconfigReq_i = 1'b1;
    if (!legal) begin
      expQ.push_back('{EV_REJECT, t + 1, modelMask});
      idleAt = t + 1;
    end else if (hold <= TO - 1) begin
      for (int c = t + 1; c <= t + 2 + hold + SETTLE; c++) expBusy[c] = 1'b1;
      expQ.push_back('{EV_CORE, t + 2 + hold, modelMask});
      modelMask = m;
      expQ.push_back('{EV_DONE, t + 3 + hold + SETTLE, m});
      idleAt = t + 3 + hold + SETTLE;
    end else begin
      for (int c = t + 1; c <= t + TO; c++) expBusy[c] = 1'b1;
      expQ.push_back('{EV_ABORT, t + 1 + TO, modelMask});
      idleAt = t + 1 + TO;
    end
    step();
    while (cyc < idleAt) begin
      if (legal && cyc <= t + hold) driveOccupied(mode);
      else driveEmpty();
      // Extra requests while draining must be ignored, legal or not.
      if (inject && legal && cyc <= t + 1 + hold) begin
        reconfigReq_i = 1'($urandom_range(0, 1));
        setReq(14'($urandom));
      end else begin
        reconfigReq_i = 1'b0;
      end
      step();
    end
    reconfigReq_i = 1'b0;
  endtask

  // Legal request, then reset in the second SETTLE cycle.
  task automatic resetDuringSettle(input logic [13:0] m);
    int t;
    t = cyc;
    setReq(m);
    reconfigReq_i = 1'b1;
    driveEmpty();
    for (int c = t + 1; c <= t + 4; c++) expBusy[c] = 1'b1;
    expQ.push_back('{EV_CORE, t + 2, modelMask});
    step();
    reconfigReq_i = 1'b0;
    while (cyc < t + 4) step();
    @(negedge clk);
    check("mask_committed_before_reset", {18'd0, dutMask}, {18'd0, m});
    reset = 1'b1;
    step();
    reset = 1'b0;
    modelMask = ALL_ONES;
    @(negedge clk);
    check("mask_after_mid_reset", {18'd0, dutMask}, {18'd0, ALL_ONES});
    check("idle_after_mid_reset", {31'd0, busy_o}, 32'd0);
    step();
  endtask

  initial begin
    logic [13:0] m;
    reset = 1'b1;
    reconfigReq_i = 1'b0;
    setReq(14'd0);
    driveEmpty();
    modelMask = ALL_ONES;
    repeat (3) step();
    @(negedge clk);
    check("reset_masks", {18'd0, dutMask}, {18'd0, ALL_ONES});
    check("reset_stall", {31'd0, stallDispatch_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_pulses", {28'd0, reconfigureCore_o, done_o, reject_o, abort_o}, 32'd0);
    step();
    reset = 1'b0;
    monOn = 1'b1;
    step();

    doTxn({4'b0011, 4'b0011, 4'b0011, 2'b01}, 0, 0, 1'b0);   // already drained
    doTxn({4'b1110, 4'b1111, 4'b1111, 2'b11}, 0, 0, 1'b0);   // illegal lane mask
    doTxn({4'b1111, 4'b1111, 4'b1110, 2'b11}, 0, 0, 1'b0);   // illegal AL mask
    doTxn({4'b0111, 4'b0101, 4'b1001, 2'b11}, 20, 0, 1'b0);  // slow drain
    doTxn({4'b1011, 4'b0011, 4'b1111, 2'b01}, 7, 1, 1'b0);   // rename holds drain
    doTxn({4'b0001, 4'b0001, 4'b0001, 2'b01}, 5, 2, 1'b0);   // count MSB only
    doTxn({4'b1111, 4'b1111, 4'b1111, 2'b11}, 6, 0, 1'b1);   // requests during DRAIN
    doTxn({4'b0101, 4'b1101, 4'b0011, 2'b11}, TO - 1, 0, 1'b0); // empty meets timeout
    doTxn({4'b0011, 4'b0011, 4'b0011, 2'b01}, TO + 3, 0, 1'b0); // timeout abort
    resetDuringSettle({4'b0011, 4'b0111, 4'b0001, 2'b01});
    doTxn({4'b1001, 4'b0011, 4'b0101, 2'b01}, 0, 0, 1'b0);   // normal after reset

    for (int i = 0; i < 50; i++) begin
      m = 14'($urandom);
      if ($urandom_range(0, 3) != 0) m = m | {4'b0001, 4'b0001, 4'b0001, 2'b01};
      if ($urandom_range(0, 2) == 0) step();
      doTxn(m, $urandom_range(0, 30), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) step();
    check("queue_drained", expQ.size(), 0);
    check("final_masks", {18'd0, dutMask}, {18'd0, modelMask});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
